word_packer_32to64: RTL and testbench
=====================================

// Module: word_packer_32to64
// PURPOSE
//  Upsizing packer: the write-side counterpart of the 64->32 half-select path. Accepts a
//  stream of 32-bit words (valid/ready) and assembles pairs into 64-bit words: first word
//  -> [31:0] (Sel=0 lane), second word -> [63:32] (Sel=1 lane). Sits between 32-bit
//  producers and the 64-bit datapath. A flush request emits a half-filled word.
// PARAMETERS
//  WORD_W     32   input word width; output width is 2*WORD_W
//  ZERO_FILL  1    1: unused upper lane on flush = 0; 0: upper lane keeps its last value
// PORTS
//  Clk          input   1         rising-edge clock
//  Reset        input   1         asynchronous, active-high reset
//  In           input   WORD_W    input word
//  InValid      input   1         In is valid this cycle
//  InReady      output  1         packer accepts In this cycle (transfer = InValid & InReady)
//  Flush        input   1         level request: emit a pending half word as partial
//  Out          output  2*WORD_W  packed word, registered
//  OutValid     output  1         Out holds an unconsumed word
//  OutReady     input   1         consumer takes Out (transfer = OutValid & OutReady)
//  OutPartial   output  1         1 = Out carries only the lower lane (flushed)
//  Sel          output  1         lane the next accepted word fills (0 low, 1 high)
// BEHAVIOUR
//  Reset (async): state=EMPTY, hold=0, Out=0, OutValid=0, OutPartial=0, Sel=0; InReady=0
//   while Reset is high.
//  State machine (2 states; Sel = state):
//   EMPTY: accepted word -> hold reg; go HALF. Flush ignored.
//   HALF : accepted word -> Out <= {In, hold}, OutValid=1, OutPartial=0; go EMPTY.
//          no word accepted & Flush & slot free -> Out <= {fill, hold}, OutPartial=1,
//          OutValid=1; go EMPTY (fill=0 if ZERO_FILL else previous Out[63:32]).
//  Slot free = !OutValid | OutReady (an output register drained this cycle is reusable).
//  InReady = !Reset & ((state==EMPTY) | slot free). Combinational path OutReady->InReady
//   is intentional; no path from InValid to InReady.
//  OutValid clears on OutReady unless a new word loads the same cycle (then stays 1).
//  Latency: Out valid the cycle after the 2nd word is accepted; throughput 1 in-word/cycle
//   with OutReady held high (one 64-bit word every 2 cycles).
//  Simultaneous InValid accept and Flush in HALF: the word completes the pair (full word,
//   OutPartial=0); Flush stays pending and has no effect because state becomes EMPTY.
//  Flush in HALF while slot not free: held off; emitted on the first cycle slot frees,
//   provided Flush still high and no word accepted that cycle.
//  Out/OutPartial stable while OutValid & !OutReady. Hold reg changes only on EMPTY accept.
//  Reset mid-pair: pending half word discarded, no partial output emitted.
// STRUCTURE
//  Shared include (packer_defs.vh): state encodings ST_EMPTY=1'b0, ST_HALF=1'b1,
//   lane constants LANE_LO=0, LANE_HI=1 (common with the 64->32 select path).
//  One sub-module: packer_out_reg (2*WORD_W+1 output register with load/drain logic,
//   OutValid generation). FSM, hold register and InReady logic stay in the top.
// TESTING
//  1 Reset then In=0x11111111,0x22222222 back-to-back, OutReady=1 -> next cycle
//    Out=0x22222222_11111111, OutValid=1, OutPartial=0; Sel 0,1,0.
//  2 Stream 8 words continuous, OutReady=1 -> 4 outputs in order, InReady never drops.
//  3 Pair complete, OutReady=0; send 3rd word (accepted, Sel=1) then 4th -> InReady=0 until
//    OutReady=1; Out stable; no word lost or duplicated.
//  4 One word 0xAAAA5555 then Flush=1 -> Out=0x00000000_AAAA5555, OutPartial=1;
//    Flush in EMPTY -> no output.
//  5 HALF, InValid=1 and Flush=1 same cycle -> full word, OutPartial=0, no extra partial.
//  6 Assert Reset asynchronously in HALF with OutValid=1 -> OutValid=0, Out=0, Sel=0
//    immediately; next pair after release packs cleanly from lane 0.

Source files
------------

// File: rtl/word_packer_32to64_pkg.sv
// word_packer_32to64_pkg: packer state encodings and lane constants shared with the 64->32 select path.
package word_packer_32to64_pkg;
   typedef enum logic {ST_EMPTY = 1'b0, ST_HALF = 1'b1} state_t;
   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;
endpackage

// File: rtl/word_packer_32to64_out_reg.sv
// word_packer_32to64_out_reg: registered packed word with partial flag; valid clears on drain unless reloaded.
module word_packer_32to64_out_reg #(
   parameter int W = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_partial,
   input  logic         i_drain,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic         o_partial
);
   logic [W-1:0] r_data;
   logic         r_valid;
   logic         r_partial;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_partial <= 1'b0;
      end else if (i_load) begin
         r_data    <= i_data;
         r_valid   <= 1'b1;
         r_partial <= i_partial;
      end else if (i_drain) begin
         r_valid   <= 1'b0;
      end
   end
   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_partial = r_partial;
endmodule

// File: rtl/word_packer_32to64.sv
// word_packer_32to64: packs pairs of WORD_W-bit words into one 2*WORD_W word (first word low lane);
// Flush emits a pending half word as a partial output.
module word_packer_32to64
   import word_packer_32to64_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter bit ZERO_FILL = 1'b1
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [WORD_W-1:0]   In,
   input  logic                InValid,
   output logic                InReady,
   input  logic                Flush,
   output logic [2*WORD_W-1:0] Out,
   output logic                OutValid,
   input  logic                OutReady,
   output logic                OutPartial,
   output logic                Sel
);
   state_t              r_state;
   state_t              w_next;
   logic [WORD_W-1:0]   r_hold;
   logic                w_slot_free;
   logic                w_accept;
   logic                w_flush;
   logic                w_load;
   logic [WORD_W-1:0]   w_fill;
   logic [2*WORD_W-1:0] w_data;
   // A draining output register is reusable in the same cycle, hence the OutReady->InReady path.
   assign w_slot_free = !OutValid | OutReady;
   assign InReady     = !Reset & ((r_state == ST_EMPTY) | w_slot_free);
   assign w_accept    = InValid & InReady;
   assign w_flush     = (r_state == ST_HALF) & !w_accept & Flush & w_slot_free;
   assign w_load      = ((r_state == ST_HALF) & w_accept) | w_flush;
   assign w_fill      = ZERO_FILL ? '0 : Out[2*WORD_W-1:WORD_W];
   assign w_data      = w_accept ? {In, r_hold} : {w_fill, r_hold};
   assign Sel         = (r_state == ST_HALF) ? LANE_HI : LANE_LO;
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = (r_state == ST_EMPTY) ? ST_HALF : ST_EMPTY;
      else if (w_flush) w_next = ST_EMPTY;
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_EMPTY;
         r_hold  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept && r_state == ST_EMPTY) r_hold <= In;
      end
   end
   word_packer_32to64_out_reg #(.W(2*WORD_W)) u_out (
      .i_clk     (Clk),
      .i_rst     (Reset),
      .i_load    (w_load),
      .i_partial (w_flush),
      .i_drain   (OutReady),
      .i_data    (w_data),
      .o_data    (Out),
      .o_valid   (OutValid),
      .o_partial (OutPartial)
   );
endmodule

// File: tb/tb_word_packer_32to64.sv
// tb_word_packer_32to64: directed stimulus with a queued scoreboard checked by an output monitor.
module tb_word_packer_32to64;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] In = '0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic        Flush = 1'b0;
   logic [63:0] Out;
   logic        OutValid;
   logic        OutReady = 1'b0;
   logic        OutPartial;
   logic        Sel;
   int          total = 0;
   int          bad = 0;
   int          stalls;
   logic [64:0] exp_q[$];
   word_packer_32to64 #(.WORD_W(32), .ZERO_FILL(1'b1)) dut (
      .Clk(Clk), .Reset(Reset), .In(In), .InValid(InValid), .InReady(InReady),
      .Flush(Flush), .Out(Out), .OutValid(OutValid), .OutReady(OutReady),
      .OutPartial(OutPartial), .Sel(Sel)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // Offer one word and hold it until accepted (bounded wait).
   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      In = w;
      InValid = 1'b1;
      @(negedge Clk);
      while (!InReady && n < 50) begin
         n++;
         @(negedge Clk);
      end
      check("accept", {64'd0, InReady}, 65'd1);
      stalls += n;
      @(posedge Clk);
      #1;
      InValid = 1'b0;
   endtask
   always @(negedge Clk) begin
      if (!Reset && OutValid && OutReady) begin
         if (exp_q.size() == 0) check("unexpected_out", {OutPartial, Out}, 65'h1_dead_beef_dead_beef);
         else check("out_word", {OutPartial, Out}, exp_q.pop_front());
      end
   end
   initial begin
      // 1: reset state and a single back-to-back pair
      #2;
      check("rst_out", {1'b0, Out}, 65'd0);
      check("rst_flags", {62'd0, OutValid, OutPartial, Sel}, 65'd0);
      check("rst_inready", {64'd0, InReady}, 65'd0);
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      OutReady = 1'b1;
      check("sel_start", {64'd0, Sel}, 65'd0);
      exp_q.push_back({1'b0, 64'h22222222_11111111});
      send(32'h11111111);
      check("sel_after_1st", {64'd0, Sel}, 65'd1);
      send(32'h22222222);
      check("sel_after_2nd", {64'd0, Sel}, 65'd0);
      check("pair_out", {OutPartial, Out}, {1'b0, 64'h22222222_11111111});
      check("pair_valid", {64'd0, OutValid}, 65'd1);
      // 2: continuous stream of 8 words, no stalls expected
      stalls = 0;
      for (int i = 0; i < 4; i++)
         exp_q.push_back({1'b0, 32'hA0000000 + 32'(2*i+1), 32'hA0000000 + 32'(2*i)});
      for (int i = 0; i < 8; i++) send(32'hA0000000 + 32'(i));
      check("stream_stalls", 65'(stalls), 65'd0);
      repeat (2) @(posedge Clk);
      #1;
      // 3: backpressure with a held output word
      OutReady = 1'b0;
      exp_q.push_back({1'b0, 64'h44444444_33333333});
      exp_q.push_back({1'b0, 64'h66666666_55555555});
      send(32'h33333333);
      send(32'h44444444);
      send(32'h55555555);
      check("bp_sel", {64'd0, Sel}, 65'd1);
      In = 32'h66666666;
      InValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("bp_inready", {64'd0, InReady}, 65'd0);
         check("bp_stable", {OutValid, Out}, {1'b1, 64'h44444444_33333333});
      end
      @(posedge Clk);
      #1;
      OutReady = 1'b1;
      send(32'h66666666);
      repeat (2) @(posedge Clk);
      #1;
      // 4: flush a half word, then flush while empty
      exp_q.push_back({1'b1, 64'h00000000_AAAA5555});
      send(32'hAAAA5555);
      Flush = 1'b1;
      @(posedge Clk);
      #1;
      Flush = 1'b0;
      check("flush_out", {OutPartial, Out}, {1'b1, 64'h00000000_AAAA5555});
      check("flush_sel", {64'd0, Sel}, 65'd0);
      repeat (2) @(posedge Clk);
      #1;
      Flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("flush_empty", {64'd0, OutValid}, 65'd0);
      end
      @(posedge Clk);
      #1;
      Flush = 1'b0;
      // 5: word and Flush together in HALF complete a full pair
      exp_q.push_back({1'b0, 64'hBBBB0002_BBBB0001});
      send(32'hBBBB0001);
      Flush = 1'b1;
      send(32'hBBBB0002);
      check("flush_word", {OutPartial, Out}, {1'b0, 64'hBBBB0002_BBBB0001});
      repeat (3) @(posedge Clk);
      #1;
      Flush = 1'b0;
      // 6: asynchronous reset mid-pair with a held output
      OutReady = 1'b0;
      send(32'hCCCC0001);
      send(32'hCCCC0002);
      send(32'hCCCC0003);
      check("pre_rst_state", {63'd0, OutValid, Sel}, 65'd3);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_out", {1'b0, Out}, 65'd0);
      check("async_rst_flags", {62'd0, OutValid, OutPartial, Sel}, 65'd0);
      check("async_rst_inready", {64'd0, InReady}, 65'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      OutReady = 1'b1;
      exp_q.push_back({1'b0, 64'hDDDD0002_DDDD0001});
      send(32'hDDDD0001);
      check("post_rst_sel", {64'd0, Sel}, 65'd1);
      send(32'hDDDD0002);
      check("post_rst_out", {OutPartial, Out}, {1'b0, 64'hDDDD0002_DDDD0001});
      repeat (3) @(posedge Clk);
      #1;
      check("queue_drained", 65'(exp_q.size()), 65'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
